writeback_arbiter: RTL and testbench

Collects completed results from the functional-unit wrappers' `fu_out_*` buses and serializes them onto the single physical-register write and peek broadcast path, then reports per-instruction completion to the ROB. Each FU gets a small private FIFO, a round-robin arbiter picks the next finished instruction, and a two-state drain FSM emits that instruction's valid destination operands one per cycle. The FUs have no `ready` input, so the block provides backpressure through a per-FU `fu_stall` signal.

---
 rtl/writeback_arbiter_if.sv | 36 +++
 rtl/writeback_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: bundle between the FU wrappers, the writeback arbiter,
// the PRF write/peek broadcast path and the ROB completion port.
interface writeback_arbiter_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int NUM_FUS      = 2
);
  logic [NUM_FUS-1:0]                                 fu_out_valid;
  logic [NUM_FUS-1:0][INST_ID_BITS-1:0]               fu_out_inst_id;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_out_prn;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0][63:0]         fu_out_data;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0]               fu_out_data_valid;
  logic [NUM_FUS-1:0]                                 fu_stall;

  logic                    wb_valid;
  logic [PRN_BITS-1:0]     wb_prn;
  logic [63:0]             wb_value;
  logic                    complete_valid;
  logic [INST_ID_BITS-1:0] complete_inst_id;
  logic                    overflow_err;

  // FU side plus the consumers of the writeback/completion outputs
  modport master (
    output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
    input  fu_stall, wb_valid, wb_prn, wb_value, complete_valid, complete_inst_id,
    input  overflow_err
  );

  // Arbiter side
  modport slave (
    input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
    output fu_stall, wb_valid, wb_prn, wb_value, complete_valid, complete_inst_id,
    output overflow_err
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-FU result FIFOs, a round-robin grant and a two-state
// drain FSM that serializes destination operands onto one PRF write port and
// then reports the instruction as complete to the ROB.
module writeback_arbiter #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int NUM_FUS      = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int FU_BITS  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT  = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] STALL_CNT = CNT_BITS'(FIFO_DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]               inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
    logic [MAX_OPERANDS-1:0][63:0]         data;
    logic [MAX_OPERANDS-1:0]               data_valid;
  } entry_t;

  entry_t                              fifo_mem_q [NUM_FUS][FIFO_DEPTH];
  logic [NUM_FUS-1:0][PTR_BITS-1:0]    rd_ptr_q, wr_ptr_q;
  logic [NUM_FUS-1:0][CNT_BITS-1:0]    count_q;
  entry_t                              in_entry [NUM_FUS];
  logic [NUM_FUS-1:0]                  fifo_nonempty, fifo_full, push, pop, stall;

  logic [0:0]                            state_q, state_d;
  logic [FU_BITS-1:0]                    rr_q, rr_d;
  logic [FU_BITS-1:0]                    grant_idx;
  logic                                  grant_valid, load;
  entry_t                                head_entry;
  logic [INST_ID_BITS-1:0]               h_id_q;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] h_prn_q;
  logic [MAX_OPERANDS-1:0][63:0]         h_data_q;
  logic [MAX_OPERANDS-1:0]               pend_q, pend_d, low_oh, pend_after;
  logic [PRN_BITS-1:0]                   sel_prn;
  logic [63:0]                           sel_data;

  logic                    wb_valid_q, wb_valid_d;
  logic [PRN_BITS-1:0]     wb_prn_q, wb_prn_d;
  logic [63:0]             wb_value_q, wb_value_d;
  logic                    complete_valid_q, complete_valid_d;
  logic [INST_ID_BITS-1:0] complete_id_q, complete_id_d;
  logic                    overflow_q, overflow_d;

  // FIFO status, push qualification (a full FIFO drops) and stall threshold
  always_comb begin
    for (int i = 0; i < NUM_FUS; i++) begin
      fifo_nonempty[i]       = (count_q[i] != '0);
      fifo_full[i]           = (count_q[i] == FULL_CNT);
      push[i]                = bus.fu_out_valid[i] && !fifo_full[i];
      stall[i]               = (count_q[i] >= STALL_CNT);
      in_entry[i].inst_id    = bus.fu_out_inst_id[i];
      in_entry[i].prn        = bus.fu_out_prn[i];
      in_entry[i].data       = bus.fu_out_data[i];
      in_entry[i].data_valid = bus.fu_out_data_valid[i];
    end
  end

  // Round-robin search from rr upward over registered counts, so a result
  // pushed on this edge cannot be granted until the next one
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NUM_FUS; off++) begin
      int cand;
      cand = int'(rr_q) + off;
      if (cand >= NUM_FUS) cand = cand - NUM_FUS;
      if (!grant_valid && fifo_nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = FU_BITS'(cand);
      end
    end
    head_entry = fifo_mem_q[grant_idx][rd_ptr_q[grant_idx]];
    rr_d = (grant_idx == FU_BITS'(NUM_FUS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Lowest pending slot of the held instruction and the operand it selects
  always_comb begin
    low_oh     = pend_q & (~pend_q + MAX_OPERANDS'(1));
    pend_after = pend_q & ~low_oh;
    sel_prn    = '0;
    sel_data   = '0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      if (low_oh[k]) begin
        sel_prn  = h_prn_q[k];
        sel_data = h_data_q[k];
      end
    end
  end

  // Drain FSM: emit one operand per edge, complete on the last one and chain
  // straight into the next granted entry so back-to-back results see no bubble
  always_comb begin
    state_d          = state_q;
    load             = 1'b0;
    pend_d           = pend_q;
    wb_valid_d       = 1'b0;
    wb_prn_d         = wb_prn_q;
    wb_value_d       = wb_value_q;
    complete_valid_d = 1'b0;
    complete_id_d    = complete_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pend_q != '0) begin
          wb_valid_d = 1'b1;
          wb_prn_d   = sel_prn;
          wb_value_d = sel_data;
          pend_d     = pend_after;
        end
        if (pend_after == '0) begin
          complete_valid_d = 1'b1;
          complete_id_d    = h_id_q;
          if (grant_valid) load = 1'b1;
          else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) pend_d = head_entry.data_valid;
    for (int i = 0; i < NUM_FUS; i++) begin
      pop[i] = load && (grant_idx == FU_BITS'(i));
    end
    overflow_d = overflow_q | (|(bus.fu_out_valid & fifo_full));
  end

  // FIFO storage; contents need no reset because pointers and counts gate them
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FUS; i++) begin
      if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= in_entry[i];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_FUS; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  // FSM, arbiter pointer, holding register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      rr_q             <= '0;
      pend_q           <= '0;
      h_id_q           <= '0;
      h_prn_q          <= '0;
      h_data_q         <= '0;
      wb_valid_q       <= 1'b0;
      wb_prn_q         <= '0;
      wb_value_q       <= '0;
      complete_valid_q <= 1'b0;
      complete_id_q    <= '0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_q           <= pend_d;
      if (load) begin
        rr_q     <= rr_d;
        h_id_q   <= head_entry.inst_id;
        h_prn_q  <= head_entry.prn;
        h_data_q <= head_entry.data;
      end
      wb_valid_q       <= wb_valid_d;
      wb_prn_q         <= wb_prn_d;
      wb_value_q       <= wb_value_d;
      complete_valid_q <= complete_valid_d;
      complete_id_q    <= complete_id_d;
      overflow_q       <= overflow_d;
    end
  end

  assign bus.fu_stall         = stall;
  assign bus.wb_valid         = wb_valid_q;
  assign bus.wb_prn           = wb_prn_q;
  assign bus.wb_value         = wb_value_q;
  assign bus.complete_valid   = complete_valid_q;
  assign bus.complete_inst_id = complete_id_q;
  assign bus.overflow_err     = overflow_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: scoreboard bench for writeback_arbiter. Expected
// writes and completions are queued as results are driven and checked as the
// arbiter emits them; fixed-latency points are checked directly.
module tb_writeback_arbiter;
  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int NUM_FUS      = 2;
  localparam int FIFO_DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;

  writeback_arbiter_if #(
    .INST_ID_BITS(INST_ID_BITS), .PRN_BITS(PRN_BITS),
    .MAX_OPERANDS(MAX_OPERANDS), .NUM_FUS(NUM_FUS)
  ) bus ();

  writeback_arbiter #(
    .INST_ID_BITS(INST_ID_BITS), .PRN_BITS(PRN_BITS), .MAX_OPERANDS(MAX_OPERANDS),
    .NUM_FUS(NUM_FUS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;
  logic [PRN_BITS+63:0]    wbQueue[$];
  logic [INST_ID_BITS-1:0] compQueue[$];
  logic                    stallSeen;

  task automatic checkOutput(input string tag, input logic [69:0] actual,
                             input logic [69:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.fu_out_valid      = '0;
    bus.fu_out_inst_id    = '0;
    bus.fu_out_prn        = '0;
    bus.fu_out_data       = '0;
    bus.fu_out_data_valid = '0;
  endtask

  // Slot k carries prn = prnBase+k and data = dataBase + k*0x11
  task automatic applyStimulus(input int fu, input logic [INST_ID_BITS-1:0] id,
                               input logic [MAX_OPERANDS-1:0] mask,
                               input logic [PRN_BITS-1:0] prnBase,
                               input logic [63:0] dataBase);
    bus.fu_out_valid[fu]      = 1'b1;
    bus.fu_out_inst_id[fu]    = id;
    bus.fu_out_data_valid[fu] = mask;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      bus.fu_out_prn[fu][k]  = prnBase + PRN_BITS'(k);
      bus.fu_out_data[fu][k] = dataBase + 64'(k) * 64'h11;
    end
  endtask

  task automatic expectResult(input logic [INST_ID_BITS-1:0] id,
                              input logic [MAX_OPERANDS-1:0] mask,
                              input logic [PRN_BITS-1:0] prnBase,
                              input logic [63:0] dataBase);
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      if (mask[k]) wbQueue.push_back({prnBase + PRN_BITS'(k), dataBase + 64'(k) * 64'h11});
    end
    compQueue.push_back(id);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while ((wbQueue.size() != 0 || compQueue.size() != 0) && n < maxCycles) begin
      nextCycle();
      n++;
    end
    checkOutput("drain_empty", 70'(wbQueue.size() + compQueue.size()), 70'(0));
    repeat (3) nextCycle();
  endtask

  // Scoreboard monitor: every write and completion must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wb_valid) begin
        if (wbQueue.size() == 0) checkOutput("wb_unexpected", 70'(bus.wb_valid), 70'(0));
        else checkOutput("wb_data", {bus.wb_prn, bus.wb_value}, wbQueue.pop_front());
      end
      if (bus.complete_valid) begin
        if (compQueue.size() == 0) checkOutput("complete_unexpected", 70'(bus.complete_valid), 70'(0));
        else checkOutput("complete_id", 70'(bus.complete_inst_id), 70'(compQueue.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clearInputs();
    repeat (3) nextCycle();
    checkOutput("rst_wb_valid", 70'(bus.wb_valid), 70'(0));
    checkOutput("rst_complete_valid", 70'(bus.complete_valid), 70'(0));
    checkOutput("rst_overflow", 70'(bus.overflow_err), 70'(0));
    checkOutput("rst_wb_bus", {bus.wb_prn, bus.wb_value}, 70'(0));
    checkOutput("rst_complete_id", 70'(bus.complete_inst_id), 70'(0));
    checkOutput("rst_stall", 70'(bus.fu_stall), 70'(0));
    rst = 1'b0;
    nextCycle();

    // Both FUs at once with rr=0: FU0 (id 1) then FU1 (id 2), no bubble
    nextCycle();
    applyStimulus(0, 6'd1, 3'b001, 6'd10, 64'h1000);
    applyStimulus(1, 6'd2, 3'b001, 6'd20, 64'h2000);
    expectResult(6'd1, 3'b001, 6'd10, 64'h1000);
    expectResult(6'd2, 3'b001, 6'd20, 64'h2000);
    nextCycle();
    clearInputs();
    repeat (2) nextCycle();
    checkOutput("pair1_first", 70'({bus.complete_valid, bus.complete_inst_id}), 70'({1'b1, 6'd1}));
    nextCycle();
    checkOutput("pair1_second", 70'({bus.complete_valid, bus.complete_inst_id}), 70'({1'b1, 6'd2}));
    waitDrain(50);

    // Single FU0 grant moves rr to 1, so the next pair starts with FU1
    nextCycle();
    applyStimulus(0, 6'd7, 3'b001, 6'd30, 64'h3000);
    expectResult(6'd7, 3'b001, 6'd30, 64'h3000);
    nextCycle();
    clearInputs();
    waitDrain(50);
    nextCycle();
    applyStimulus(0, 6'd8, 3'b001, 6'd12, 64'h4000);
    applyStimulus(1, 6'd9, 3'b001, 6'd22, 64'h5000);
    expectResult(6'd9, 3'b001, 6'd22, 64'h5000);
    expectResult(6'd8, 3'b001, 6'd12, 64'h4000);
    nextCycle();
    clearInputs();
    repeat (2) nextCycle();
    checkOutput("pair2_first", 70'({bus.complete_valid, bus.complete_inst_id}), 70'({1'b1, 6'd9}));
    nextCycle();
    checkOutput("pair2_second", 70'({bus.complete_valid, bus.complete_inst_id}), 70'({1'b1, 6'd8}));
    waitDrain(50);

    // Two-operand result in slots 0 and 2, nominal latency
    nextCycle();
    applyStimulus(0, 6'd5, 3'b101, 6'd7, 64'hAA);
    expectResult(6'd5, 3'b101, 6'd7, 64'hAA);
    nextCycle();
    clearInputs();
    nextCycle();
    checkOutput("t1_c2_quiet", 70'({bus.wb_valid, bus.complete_valid}), 70'(0));
    nextCycle();
    checkOutput("t1_c3_wb", {bus.wb_valid, bus.wb_prn, bus.wb_value}, {1'b1, 6'd7, 64'hAA});
    checkOutput("t1_c3_nocomp", 70'(bus.complete_valid), 70'(0));
    nextCycle();
    checkOutput("t1_c4_wb", {bus.wb_valid, bus.wb_prn, bus.wb_value}, {1'b1, 6'd9, 64'hCC});
    checkOutput("t1_c4_comp", 70'({bus.complete_valid, bus.complete_inst_id}), 70'({1'b1, 6'd5}));
    nextCycle();
    checkOutput("t1_c5_quiet", 70'({bus.wb_valid, bus.complete_valid}), 70'(0));
    waitDrain(50);

    // Zero-operand result: completion alone in cycle 3
    nextCycle();
    applyStimulus(0, 6'd3, 3'b000, 6'd1, 64'h0);
    expectResult(6'd3, 3'b000, 6'd1, 64'h0);
    nextCycle();
    clearInputs();
    nextCycle();
    checkOutput("t2_c2_quiet", 70'(bus.complete_valid), 70'(0));
    nextCycle();
    checkOutput("t2_c3_comp", 70'({bus.wb_valid, bus.complete_valid, bus.complete_inst_id}),
                70'({1'b0, 1'b1, 6'd3}));
    nextCycle();
    checkOutput("t2_c4_quiet", 70'(bus.complete_valid), 70'(0));
    waitDrain(50);

    // FU0 pushes three-operand results whenever it is not stalled
    stallSeen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      nextCycle();
      clearInputs();
      if (bus.fu_stall[0]) stallSeen = 1'b1;
      else begin
        applyStimulus(0, 6'(40 + c), 3'b111, 6'(c * 3), 64'(c) << 32);
        expectResult(6'(40 + c), 3'b111, 6'(c * 3), 64'(c) << 32);
      end
    end
    nextCycle();
    clearInputs();
    checkOutput("obey_no_overflow", 70'(bus.overflow_err), 70'(0));
    checkOutput("obey_stall_seen", 70'(stallSeen), 70'(1));
    waitDrain(200);

    // FU0 ignores stall: count reaches 3 after the fourth edge and the push
    // at the seventh edge meets a full FIFO and is dropped (id 26)
    for (int c = 0; c < 7; c++) begin
      nextCycle();
      clearInputs();
      if (c == 3) checkOutput("force_stall_low", 70'(bus.fu_stall[0]), 70'(0));
      if (c == 4) checkOutput("force_stall_high", 70'(bus.fu_stall[0]), 70'(1));
      if (c == 6) checkOutput("force_no_overflow_yet", 70'(bus.overflow_err), 70'(0));
      applyStimulus(0, 6'(20 + c), 3'b111, 6'(10 + c * 3), 64'hF000 + 64'(c) * 64'h100);
      if (c < 6) expectResult(6'(20 + c), 3'b111, 6'(10 + c * 3), 64'hF000 + 64'(c) * 64'h100);
    end
    nextCycle();
    clearInputs();
    checkOutput("force_overflow_set", 70'(bus.overflow_err), 70'(1));
    waitDrain(100);
    checkOutput("overflow_sticky", 70'(bus.overflow_err), 70'(1));

    // Reset during the second operand of a three-operand drain
    nextCycle();
    applyStimulus(0, 6'd30, 3'b111, 6'd1, 64'h100);
    expectResult(6'd30, 3'b111, 6'd1, 64'h100);
    nextCycle();
    clearInputs();
    repeat (2) nextCycle();
    checkOutput("rstmid_c3_wb", {bus.wb_valid, bus.wb_prn, bus.wb_value}, {1'b1, 6'd1, 64'h100});
    nextCycle();
    checkOutput("rstmid_c4_wb", {bus.wb_valid, bus.wb_prn, bus.wb_value}, {1'b1, 6'd2, 64'h111});
    rst = 1'b1;
    wbQueue.delete();
    compQueue.delete();
    nextCycle();
    checkOutput("rstmid_valids", 70'({bus.wb_valid, bus.complete_valid, bus.overflow_err}), 70'(0));
    checkOutput("rstmid_wb_bus", {bus.wb_prn, bus.wb_value}, 70'(0));
    checkOutput("rstmid_complete_id", 70'(bus.complete_inst_id), 70'(0));
    rst = 1'b0;
    repeat (6) nextCycle();

    // Fresh result on FU1 after reset completes with nominal latency
    nextCycle();
    applyStimulus(1, 6'd31, 3'b011, 6'd50, 64'h5000);
    expectResult(6'd31, 3'b011, 6'd50, 64'h5000);
    nextCycle();
    clearInputs();
    repeat (2) nextCycle();
    checkOutput("fresh_c3_wb", {bus.wb_valid, bus.wb_prn, bus.wb_value}, {1'b1, 6'd50, 64'h5000});
    nextCycle();
    checkOutput("fresh_c4_wb", {bus.wb_valid, bus.wb_prn, bus.wb_value}, {1'b1, 6'd51, 64'h5011});
    checkOutput("fresh_c4_comp", 70'({bus.complete_valid, bus.complete_inst_id}), 70'({1'b1, 6'd31}));
    waitDrain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
